// File: rtl/iob_spi_flash_prefetch_pkg.sv
// Shared constants and FSM encoding for the SPI flash read-prefetch line buffer.
package iob_spi_flash_prefetch_pkg;

  localparam int ADDR_W_DEF       = 24;
  localparam int DATA_W_DEF       = 32;
  localparam int LINE_WORDS_W_DEF = 2;
  localparam int LINE_WORDS       = 2 ** LINE_WORDS_W_DEF;
  localparam int TAG_W            = ADDR_W_DEF - LINE_WORDS_W_DEF - 2;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RESP     = 2'd1;
  localparam logic [1:0] ST_FILL_REQ = 2'd2;
  localparam logic [1:0] ST_FILL_GAP = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    RESP     = ST_RESP,
    FILL_REQ = ST_FILL_REQ,
    FILL_GAP = ST_FILL_GAP
  } state_e;

endpackage

// File: rtl/iob_spi_flash_prefetch.sv
// Single-line read prefetch buffer in front of the SPI flash controller read port.
// Hits are served from the buffered line; misses refill the whole line word by word.
module iob_spi_flash_prefetch
  import iob_spi_flash_prefetch_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int LINE_WORDS_W = LINE_WORDS_W_DEF
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              flush_i,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  output logic              req_rvalid_o,
  output logic [DATA_W-1:0] req_rdata_o,
  output logic              fl_valid_o,
  output logic [ADDR_W-1:0] fl_addr_o,
  input  logic              fl_ready_i,
  input  logic [DATA_W-1:0] fl_rdata_i,
  output logic              busy_o
);

  localparam int LW = 2 ** LINE_WORDS_W;
  localparam int TW = ADDR_W - LINE_WORDS_W - 2;
  localparam logic [LINE_WORDS_W-1:0] BEAT_LAST = LINE_WORDS_W'(LW - 1);
  localparam logic [LINE_WORDS_W-1:0] BEAT_ONE  = LINE_WORDS_W'(1);

  state_e                  r_state;
  logic [DATA_W-1:0]       r_line [LW];
  logic [TW-1:0]           r_tag;
  logic                    r_line_valid;
  logic                    r_flush_pend;
  logic [LINE_WORDS_W-1:0] r_beat;
  logic                    r_req_ready;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_fl_valid;
  logic [ADDR_W-1:0]       r_fl_addr;
  logic                    r_busy;

  logic [TW-1:0]           w_tag;
  logic [LINE_WORDS_W-1:0] w_idx;
  logic                    w_hit;

  assign w_tag = req_addr_i[ADDR_W-1:LINE_WORDS_W+2];
  assign w_idx = req_addr_i[LINE_WORDS_W+1:2];
  assign w_hit = r_line_valid && (w_tag == r_tag);

  // Control FSM together with every registered output
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state      <= IDLE;
      r_tag        <= '0;
      r_line_valid <= 1'b0;
      r_flush_pend <= 1'b0;
      r_beat       <= '0;
      r_req_ready  <= 1'b0;
      r_rdata      <= '0;
      r_fl_valid   <= 1'b0;
      r_fl_addr    <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i && w_hit) begin
            r_rdata     <= r_line[w_idx];
            r_req_ready <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= RESP;
            if (flush_i) r_line_valid <= 1'b0;
          end else if (req_valid_i) begin
            // A flush coinciding with the miss applies to the line being fetched
            r_tag        <= w_tag;
            r_line_valid <= 1'b0;
            r_flush_pend <= flush_i;
            r_beat       <= '0;
            r_fl_valid   <= 1'b1;
            r_fl_addr    <= {w_tag, {LINE_WORDS_W{1'b0}}, 2'b00};
            r_busy       <= 1'b1;
            r_state      <= FILL_REQ;
          end else if (flush_i || r_flush_pend) begin
            r_line_valid <= 1'b0;
            r_flush_pend <= 1'b0;
          end
        end
        RESP: begin
          r_req_ready <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
          if (flush_i || r_flush_pend) begin
            r_line_valid <= 1'b0;
            r_flush_pend <= 1'b0;
          end
        end
        FILL_REQ: begin
          if (flush_i) r_flush_pend <= 1'b1;
          if (fl_ready_i) begin
            r_fl_valid <= 1'b0;
            if (r_beat == BEAT_LAST) begin
              r_line_valid <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= IDLE;
            end else begin
              r_beat  <= r_beat + BEAT_ONE;
              r_state <= FILL_GAP;
            end
          end
        end
        FILL_GAP: begin
          // One low cycle keeps consecutive beats distinct transactions
          if (flush_i) r_flush_pend <= 1'b1;
          r_fl_valid <= 1'b1;
          r_fl_addr  <= {r_tag, r_beat, 2'b00};
          r_state    <= FILL_REQ;
        end
        default: begin
          r_req_ready <= 1'b0;
          r_fl_valid  <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // Line storage, written only by accepted fill beats and never reset
  always_ff @(posedge clk_i) begin
    if ((r_state == FILL_REQ) && fl_ready_i) r_line[r_beat] <= fl_rdata_i;
  end

  assign req_ready_o  = r_req_ready;
  assign req_rvalid_o = r_req_ready;
  assign req_rdata_o  = r_rdata;
  assign fl_valid_o   = r_fl_valid;
  assign fl_addr_o    = r_fl_addr;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_iob_spi_flash_prefetch.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized reads checked against a line-level reference model.
module tb_iob_spi_flash_prefetch;

  logic        clk_i       = 1'b0;
  logic        arst_i      = 1'b1;
  logic        flush_i     = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [23:0] req_addr_i  = 24'h0;
  logic        req_ready_o;
  logic        req_rvalid_o;
  logic [31:0] req_rdata_o;
  logic        fl_valid_o;
  logic [23:0] fl_addr_o;
  logic        fl_ready_i  = 1'b0;
  logic [31:0] fl_rdata_i  = 32'h0;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  iob_spi_flash_prefetch dut (
    .clk_i(clk_i), .arst_i(arst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
    .req_ready_o(req_ready_o), .req_rvalid_o(req_rvalid_o), .req_rdata_o(req_rdata_o),
    .fl_valid_o(fl_valid_o), .fl_addr_o(fl_addr_o),
    .fl_ready_i(fl_ready_i), .fl_rdata_i(fl_rdata_i), .busy_o(busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] fl_log[$];
  int ack_cnt = 0, gap_err = 0, rv_err = 0;
  int ctl_lat = 5, ctl_cnt = 0;
  bit acc_prev = 1'b0, spur_en = 1'b0;

  // Flash contents: each word holds its own word-aligned address
  function automatic logic [31:0] exp_word(input logic [23:0] a);
    return {8'h00, a[23:2], 2'b00};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Controller model plus output monitors, evaluated mid-cycle
  always @(negedge clk_i) begin
    if (arst_i) begin
      fl_ready_i = 1'b0;
      ctl_cnt    = 0;
      acc_prev   = 1'b0;
    end else begin
      if (acc_prev && fl_valid_o) gap_err++;
      acc_prev   = 1'b0;
      fl_ready_i = 1'b0;
      if (fl_valid_o) begin
        ctl_cnt++;
        if (ctl_cnt >= ctl_lat) begin
          fl_ready_i = 1'b1;
          fl_rdata_i = exp_word(fl_addr_o);
          fl_log.push_back(fl_addr_o);
          acc_prev   = 1'b1;
          ctl_cnt    = 0;
        end
      end else begin
        ctl_cnt = 0;
        if (spur_en && ($urandom_range(0, 2) == 0)) begin
          fl_ready_i = 1'b1;
          fl_rdata_i = $urandom;
        end
      end
      if (req_ready_o) ack_cnt++;
      if (req_rvalid_o !== req_ready_o) rv_err++;
    end
  end

  task automatic read_op(input logic [23:0] addr, input int flush_at,
                         output logic [31:0] data, output int n, output bit to);
    bit got;
    got = 1'b0;
    n   = 0;
    data = 32'h0;
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    while (!got && n < 400) begin
      flush_i = (n == flush_at);
      @(negedge clk_i);
      n++;
      if (req_ready_o) begin
        got  = 1'b1;
        data = req_rdata_o;
      end
    end
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    to          = !got;
    @(negedge clk_i);
  endtask

  task automatic check_read(input logic [23:0] addr, input int flush_at, input bit miss,
                            input logic [31:0] exp_data, input int exp_lat, input string nm);
    int b0, a0, n, nb;
    logic [31:0] d;
    bit to, ok;
    logic [23:0] base;
    b0 = fl_log.size();
    a0 = ack_cnt;
    read_op(addr, flush_at, d, n, to);
    chk({nm, " timeout"}, 64'(to), 64'd0);
    chk({nm, " data"}, 64'(d), 64'(exp_data));
    chk({nm, " latency"}, 64'(n), 64'(exp_lat));
    chk({nm, " acks"}, 64'(ack_cnt - a0), 64'd1);
    nb = fl_log.size() - b0;
    chk({nm, " beats"}, 64'(nb), miss ? 64'd4 : 64'd0);
    base = {addr[23:4], 4'h0};
    ok = 1'b1;
    for (int i = 0; i < nb && i < 4; i++)
      if (fl_log[b0 + i] !== base + 24'(4 * i)) ok = 1'b0;
    if (miss) chk({nm, " beat addrs"}, 64'(ok), 64'd1);
  endtask

  task automatic flush_pulse();
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  typedef struct {
    logic [23:0] addr;
    bit          pre_flush;
    int          flush_at;
    bit          miss;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [23:0] bases[3];
    logic [23:0] m_base, ad, lb;
    bit          m_valid, miss;
    int          a0, b0, k, last, fa, el;
    bit          ok_sp;

    vecs[0]  = '{24'h000104, 1'b0, -1, 1'b1, 32'h00000104};
    vecs[1]  = '{24'h00010C, 1'b0, -1, 1'b0, 32'h0000010C};
    vecs[2]  = '{24'h000200, 1'b0, -1, 1'b1, 32'h00000200};
    vecs[3]  = '{24'h000104, 1'b0, -1, 1'b1, 32'h00000104};
    vecs[4]  = '{24'h00010B, 1'b0, -1, 1'b0, 32'h00000108};
    vecs[5]  = '{24'h000104, 1'b1, -1, 1'b1, 32'h00000104};
    vecs[6]  = '{24'h000100, 1'b0, -1, 1'b0, 32'h00000100};
    vecs[7]  = '{24'hFFFFFC, 1'b0, -1, 1'b1, 32'h00FFFFFC};
    vecs[8]  = '{24'hFFFFF1, 1'b0, -1, 1'b0, 32'h00FFFFF0};
    vecs[9]  = '{24'h00000C, 1'b0,  0, 1'b1, 32'h0000000C};
    vecs[10] = '{24'h000000, 1'b0, -1, 1'b1, 32'h00000000};

    #3;
    chk("reset outputs", 64'({req_ready_o, req_rvalid_o, req_rdata_o, fl_valid_o, fl_addr_o, busy_o}), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    arst_i = 1'b0;

    // Directed table at controller latency 5: miss = 4*5+5 cycles, hit = 1
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].pre_flush) flush_pulse();
      check_read(vecs[i].addr, vecs[i].flush_at, vecs[i].miss, vecs[i].data,
                 vecs[i].miss ? 25 : 1, $sformatf("vec%0d", i));
    end

    // Flush during the second beat: served once, then the line refills
    check_read(24'h000300, 9, 1'b1, 32'h00000300, 25, "midflush");
    check_read(24'h000304, -1, 1'b1, 32'h00000304, 25, "midflush refill");

    // Asynchronous reset in the middle of a fill
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_addr_i  = 24'h000500;
    repeat (3) @(negedge clk_i);
    chk("prereset fl_valid", 64'(fl_valid_o), 64'd1);
    chk("prereset busy", 64'(busy_o), 64'd1);
    #2 arst_i = 1'b1;
    #1;
    chk("reset fl_valid", 64'(fl_valid_o), 64'd0);
    chk("reset busy", 64'(busy_o), 64'd0);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    arst_i = 1'b0;
    check_read(24'h000504, -1, 1'b1, 32'h00000504, 25, "postreset");

    // Back-to-back hits with request held high across the whole line
    check_read(24'h000100, -1, 1'b1, 32'h00000100, 25, "b2b fill");
    a0 = ack_cnt;
    b0 = fl_log.size();
    k = 0;
    last = -1;
    ok_sp = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_addr_i  = 24'h000100;
    for (int c = 1; c <= 40 && k < 4; c++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        chk($sformatf("b2b data%0d", k), 64'(req_rdata_o), 64'(32'h100 + 32'(4 * k)));
        if (last >= 0 && (c - last) != 2) ok_sp = 1'b0;
        last = c;
        k++;
        req_addr_i = 24'h000100 + 24'(4 * k);
        if (k == 4) req_valid_i = 1'b0;
      end
    end
    req_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("b2b count", 64'(k), 64'd4);
    chk("b2b spacing", 64'(ok_sp), 64'd1);
    chk("b2b acks", 64'(ack_cnt - a0), 64'd4);
    chk("b2b no flash", 64'(fl_log.size() - b0), 64'd0);

    // Randomized reads against a line-level model
    bases[0] = 24'h000100;
    bases[1] = 24'h000200;
    bases[2] = 24'hABCDE0;
    flush_pulse();
    m_valid = 1'b0;
    m_base  = 24'h0;
    spur_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 99) < 12) begin
        flush_pulse();
        m_valid = 1'b0;
      end else begin
        lb = bases[$urandom_range(0, 2)];
        ad = lb + 24'($urandom_range(0, 15));
        ctl_lat = $urandom_range(1, 6);
        fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : -1;
        miss = !(m_valid && (m_base == lb));
        el = miss ? (4 * ctl_lat + 5) : 1;
        check_read(ad, fa, miss, exp_word(ad), el, $sformatf("rnd%0d", i));
        m_valid = 1'b1;
        m_base  = lb;
        if (fa >= 0 && fa < el) m_valid = 1'b0;
      end
    end
    spur_en = 1'b0;
    repeat (2) @(negedge clk_i);

    chk("fill gap", 64'(gap_err), 64'd0);
    chk("rvalid tracks ready", 64'(rv_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_spi_flash_prefetch.md
# iob_spi_flash_prefetch

Read-prefetch line buffer that sits directly upstream of the SPI flash controller's memory-mapped read port. It accepts word reads from a CPU/cache bus. It serves hits from a single buffered line of `2**LINE_WORDS_W` words. On a miss it refills the whole line through sequential single-word flash read transactions on the controller's valid/address/ready handshake. This turns execute-in-place instruction fetch into mostly-local accesses.

## Interface
- `ADDR_W`, 24, flash byte-address width.
- `DATA_W`, 32, word width; fixed at 32.
- `LINE_WORDS_W`, 2, log2 of words per line (4 words, 16 bytes).
- `clk_i`  in  1  clock.
- `arst_i`  in  1  reset; asynchronous, active-high.
- `flush_i`  in  1  invalidate the line (single-cycle pulse or level).
- `req_valid_i`  in  1  read request; held high until `req_ready_o`.
- `req_addr_i`  in  ADDR_W  byte address; bits [1:0] ignored.
- `req_ready_o`  out  1  one-cycle acknowledge.
- `req_rvalid_o`  out  1  asserted together with `req_ready_o`.
- `req_rdata_o`  out  DATA_W  read data, valid while `req_rvalid_o`.
- `fl_valid_o`  out  1  flash word-read request to the controller.
- `fl_addr_o`  out  ADDR_W  flash byte address, word aligned.
- `fl_ready_i`  in  1  controller done; `fl_rdata_i` valid this cycle.
- `fl_rdata_i`  in  DATA_W  word returned by the controller.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- Address split:
  - tag = `req_addr_i[ADDR_W-1:LINE_WORDS_W+2]`
  - idx = `req_addr_i[LINE_WORDS_W+1:2]`
- Storage: `line_q[0..2**LINE_WORDS_W-1]`, `tag_q`, `line_valid_q`.
- Hit condition: `line_valid_q && tag == tag_q`.
- FSM states: IDLE, RESP, FILL_REQ, FILL_GAP.
  - IDLE, on `req_valid_i` and hit: register `line_q[idx]` into `req_rdata_o`, go to RESP.
  - IDLE, on `req_valid_i` and miss: latch `tag_q` = tag, clear `line_valid_q`, clear `beat_q`, go to FILL_REQ.
  - RESP: `req_ready_o` = `req_rvalid_o` = 1 for exactly one cycle, then IDLE.
  - FILL_REQ: `fl_valid_o` = 1 and `fl_addr_o` = {`tag_q`, `beat_q`, 2'b00}, both held stable. When `fl_ready_i` = 1, write `line_q[beat_q]` = `fl_rdata_i`, then:
    - if `beat_q` is the last beat: set `line_valid_q`, go to IDLE; the held request now hits.
    - otherwise: increment `beat_q`, go to FILL_GAP.
  - FILL_GAP: `fl_valid_o` = 0 for one cycle, then FILL_REQ. This prevents the controller from seeing one valid span as two transactions.
- Fill order: word 0 to the last word, no critical-word-first. `beat_q` is LINE_WORDS_W bits wide and never wraps mid-fill.
- `fl_ready_i` is ignored when `fl_valid_o` = 0.
- Flush in IDLE or RESP: `line_valid_q` is cleared the next cycle.
- Flush during a fill:
  - It is recorded in `flush_pend_q`; an in-flight flash transaction is never aborted.
  - The fill completes and the pending request is served once from the new line.
  - `line_valid_q` is cleared on leaving RESP; `flush_pend_q` is then cleared.
- Flush in the same cycle as a miss decision in IDLE: the miss proceeds and the flush is recorded as pending.
- `req_valid_i` dropping before `req_ready_o` is a protocol violation; behaviour is undefined, but the FSM must always return to IDLE.

## Timing
- Reset values: all outputs 0, `line_valid_q` = 0, `flush_pend_q` = 0, state IDLE, `beat_q` = 0. `line_q` is not reset.
- Hit latency: request sampled in cycle N, `req_ready_o` in cycle N+1. Maximum hit throughput is one request per 2 cycles.
- Miss latency:
  - `fl_valid_o` rises in N+1.
  - Each beat takes controller latency plus 1 gap cycle.
  - `req_ready_o` comes 2 cycles after the last `fl_ready_i` (IDLE re-check, then RESP).
- `fl_valid_o`, `fl_addr_o`, `req_*` and `busy_o` are all registered outputs; no combinational path from input to output.
- `arst_i` mid-fill returns the block to reset values immediately. The controller's own reset is expected to be asserted with it.

## Structure
- Shared package `iob_spi_flash_prefetch_pkg`:
  - state encoding localparams (IDLE = 0, RESP = 1, FILL_REQ = 2, FILL_GAP = 3)
  - `LINE_WORDS` = `2**LINE_WORDS_W`
  - `TAG_W` = `ADDR_W-LINE_WORDS_W-2`
- No sub-module; the line buffer is a small register array inside the block.

## Test plan
- Miss then hit:
  - Read 0x000104 with the controller model returning address-as-data after 5 cycles.
  - Required: 4 `fl_valid_o` beats at 0x100, 0x104, 0x108, 0x10C, each separated by ≥1 low cycle.
  - Required: `req_rdata_o` = 0x104; then a read of 0x10C returns 0x10C in 1 cycle with no `fl_valid_o`.
- Line replacement:
  - After the fill of 0x100, read 0x200.
  - Required: a new 4-beat fill at 0x200–0x20C; then 0x104 misses again.
- Flush in IDLE: pulse `flush_i`, re-read 0x104 → full refill observed.
- Flush mid-fill:
  - Pulse `flush_i` during beat 2.
  - Required: the fill completes and the request returns correct data once.
  - Required: the next read of the same line triggers a refill.
- Reset mid-fill:
  - Assert `arst_i` during FILL_REQ.
  - Required: `fl_valid_o` = 0 and `busy_o` = 0 immediately; the next read misses.
- Back-to-back hits:
  - Hold `req_valid_i` continuously over 0x100..0x10C after the fill.
  - Required: `req_ready_o` every second cycle with correct data, and no duplicate acknowledgements.
